sort_report_packer: RTL and testbench
=====================================

SORT_REPORT_PACKER -- requirements
Module: sort_report_packer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 4, the width of a sorted data value (legal range 1..8).
REQ-002 SHALL have parameter LENGTH_SIZE, default 6, the width of an occurrence count (legal range 1..8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port SortValid, input, 1 bit: a one-cycle pulse marking a new top-3 result from the sorter.
REQ-006 SHALL have ports MaxCountData1/2/3, input, DATA_SIZE bits each: the data values ranked 1st, 2nd and 3rd.
REQ-007 SHALL have ports MaxCount1/2/3, input, LENGTH_SIZE bits each: the matching occurrence counts.
REQ-008 SHALL have port OutData, output, 8 bits: the packet byte.
REQ-009 SHALL have port OutValid, output, 1 bit: OutData is valid.
REQ-010 SHALL have port OutReady, input, 1 bit: the consumer accepts a byte; a transfer occurs when OutValid and OutReady are both high.
REQ-011 SHALL have port OutLast, output, 1 bit: marks the final byte of a packet.
REQ-012 SHALL have port DropCount, output, 8 bits: the number of results lost to overrun.
REQ-013 SHALL have port Busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL capture all six inputs into an active register on SortValid when IDLE, then enter SEND with byte index 0.
REQ-015 SHALL assert OutValid with byte 0 on the cycle after SortValid (latency 1).
REQ-016 SHALL emit a 9-byte packet in this order:
  - 0xA5
  - SeqNum
  - Data1, Count1
  - Data2, Count2
  - Data3, Count3
  - checksum
REQ-017 SHALL zero-extend every data and count field to 8 bits.
REQ-018 SHALL compute the checksum as the XOR of bytes 0..7.
REQ-019 SHALL hold OutData, OutValid and OutLast stable while OutValid=1 and OutReady=0.
REQ-020 SHALL advance the byte index only on a transfer.
REQ-021 SHALL assert OutLast only together with byte 8.
REQ-022 SHALL hold an 8-bit SeqNum and increment it, wrapping 0xFF to 0x00, on the transfer of byte 8.
REQ-023 SHALL latch a SortValid arriving in SEND into a one-deep pending register when the pending register is empty.
REQ-024 SHALL discard a SortValid arriving in SEND when the pending register is full, keep the existing pending contents, and increment DropCount, saturating at 0xFF.
REQ-025 SHALL, on the transfer of byte 8 with pending full, load pending into active, clear pending, and drive byte 0 of the next packet on the following cycle with no idle cycle.
REQ-026 SHALL, on the transfer of byte 8 with pending empty and SortValid high in the same cycle, capture the inputs directly into active and remain in SEND at index 0.
REQ-027 SHALL, on the transfer of byte 8 with pending full and SortValid high in the same cycle, move pending to active and store the new inputs into pending, with no drop.
REQ-028 SHALL return to IDLE with OutValid=0 after the transfer of byte 8 when pending is empty and SortValid is low.
REQ-029 SHALL use exactly two states, IDLE and SEND, with no other state.

Reset
REQ-030 SHALL, while rst=1, drive OutValid=0, OutData=0x00, OutLast=0, Busy=0, DropCount=0, SeqNum=0, set the state to IDLE and clear pending.
REQ-031 SHALL abandon any packet in flight when rst is asserted mid-packet and SHALL NOT resume it after release.
REQ-032 SHALL ignore a SortValid that coincides with rst=1.

Verification
REQ-033 SHALL be checked with this single packet: OutReady=1, SortValid carrying D1=3/C1=20, D2=7/C2=15, D3=0/C3=9 -> bytes A5,00,03,14,07,0F,00,09,B3 on 9 consecutive cycles, OutLast only on B3, then Busy=0.
REQ-034 SHALL be checked with backpressure: OutReady toggling 1010... during the REQ-033 packet -> identical byte sequence, and each byte held stable while OutReady=0.
REQ-035 SHALL be checked with back-to-back results: a second SortValid at byte 3 -> second packet with SeqNum=01 starts on the cycle after the B3 transfer, and DropCount=0.
REQ-036 SHALL be checked with overrun: three SortValid pulses during one packet -> the 2nd result is sent next, the 3rd is lost, and DropCount=1.
REQ-037 SHALL be checked with reset mid-packet: rst pulsed at byte 4 -> OutValid=0 and SeqNum=0 after reset, and the next SortValid produces a packet whose SeqNum byte is 00.
REQ-038 SHALL be checked with wrap and saturation: 256 packets -> SeqNum returns to 00; 300 forced drops -> DropCount=FF.

Source files
------------

// File: rtl/sort_report_packer.sv
// Packs a sorter's top-3 result into a 9-byte valid/ready packet with a sequence number
// and an XOR checksum. One result can wait while a packet is in flight; further results are counted as drops.
module sort_report_packer #(
  parameter int DATA_SIZE   = 4,
  parameter int LENGTH_SIZE = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SortValid,
  input  logic [DATA_SIZE-1:0]   MaxCountData1,
  input  logic [DATA_SIZE-1:0]   MaxCountData2,
  input  logic [DATA_SIZE-1:0]   MaxCountData3,
  input  logic [LENGTH_SIZE-1:0] MaxCount1,
  input  logic [LENGTH_SIZE-1:0] MaxCount2,
  input  logic [LENGTH_SIZE-1:0] MaxCount3,
  output logic [7:0]             OutData,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic                   OutLast,
  output logic [7:0]             DropCount,
  output logic                   Busy
);

  typedef struct packed {
    logic [DATA_SIZE-1:0]   d1;
    logic [LENGTH_SIZE-1:0] c1;
    logic [DATA_SIZE-1:0]   d2;
    logic [LENGTH_SIZE-1:0] c2;
    logic [DATA_SIZE-1:0]   d3;
    logic [LENGTH_SIZE-1:0] c3;
  } result_t;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t     state, state_nx;
  result_t    active, active_nx;
  result_t    pending, pending_nx;
  result_t    incoming;
  logic       pend_full, pend_full_nx;
  logic [3:0] idx, idx_nx;
  logic [7:0] seq_num, seq_nx;
  logic [7:0] drop_nx;
  logic       xfer;
  logic       last_byte;
  logic       out_valid_nx;
  logic [7:0] out_data_nx;
  logic       out_last_nx;

  // XOR of packet bytes 0..7, i.e. the checksum byte
  function automatic logic [7:0] xor_sum(input result_t r, input logic [7:0] seq);
    return 8'hA5 ^ seq ^ 8'(r.d1) ^ 8'(r.c1) ^ 8'(r.d2) ^ 8'(r.c2) ^ 8'(r.d3) ^ 8'(r.c3);
  endfunction

  function automatic logic [7:0] pkt_byte(input result_t r, input logic [7:0] seq,
                                          input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = 8'hA5;
      4'd1:    b = seq;
      4'd2:    b = 8'(r.d1);
      4'd3:    b = 8'(r.c1);
      4'd4:    b = 8'(r.d2);
      4'd5:    b = 8'(r.c2);
      4'd6:    b = 8'(r.d3);
      4'd7:    b = 8'(r.c3);
      4'd8:    b = xor_sum(r, seq);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign incoming  = '{d1: MaxCountData1, c1: MaxCount1,
                       d2: MaxCountData2, c2: MaxCount2,
                       d3: MaxCountData3, c3: MaxCount3};
  assign xfer      = OutValid & OutReady;
  assign last_byte = (idx == 4'd8);

  // Next-state, buffering and next output byte
  always_comb begin
    state_nx     = state;
    active_nx    = active;
    pending_nx   = pending;
    pend_full_nx = pend_full;
    idx_nx       = idx;
    seq_nx       = seq_num;
    drop_nx      = DropCount;
    case (state)
      IDLE: begin
        if (SortValid) begin
          active_nx = incoming;
          idx_nx    = 4'd0;
          state_nx  = SEND;
        end else begin
          state_nx  = IDLE;
        end
      end
      SEND: begin
        if (xfer && last_byte) begin
          seq_nx = seq_num + 8'd1;
          idx_nx = 4'd0;
          // A pending result goes next; a coincident new result takes its place, no drop.
          if (pend_full) begin
            active_nx = pending;
            if (SortValid) begin
              pending_nx = incoming;
            end else begin
              pend_full_nx = 1'b0;
            end
          end else if (SortValid) begin
            active_nx = incoming;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_nx = idx + 4'd1;
          end else begin
            idx_nx = idx;
          end
          if (SortValid) begin
            if (!pend_full) begin
              pending_nx   = incoming;
              pend_full_nx = 1'b1;
            end else if (DropCount != 8'hFF) begin
              drop_nx = DropCount + 8'd1;
            end else begin
              drop_nx = DropCount;
            end
          end else begin
            pend_full_nx = pend_full;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    out_valid_nx = (state_nx == SEND);
    if (out_valid_nx) begin
      out_data_nx = pkt_byte(active_nx, seq_nx, idx_nx);
      out_last_nx = (idx_nx == 4'd8);
    end else begin
      out_data_nx = 8'h00;
      out_last_nx = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      idx       <= 4'd0;
      seq_num   <= 8'h00;
      DropCount <= 8'h00;
      OutValid  <= 1'b0;
      OutData   <= 8'h00;
      OutLast   <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      active    <= active_nx;
      pending   <= pending_nx;
      pend_full <= pend_full_nx;
      idx       <= idx_nx;
      seq_num   <= seq_nx;
      DropCount <= drop_nx;
      OutValid  <= out_valid_nx;
      OutData   <= out_data_nx;
      OutLast   <= out_last_nx;
      Busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_sort_report_packer.sv
// Directed self-checking bench for sort_report_packer: packet format, backpressure,
// buffering/overrun, mid-packet reset, sequence wrap and drop saturation.
module tb_sort_report_packer;

  typedef logic [7:0] pkt_t [9];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SortValid = 1'b0;
  logic [3:0] d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;
  logic [5:0] c1 = 6'd0, c2 = 6'd0, c3 = 6'd0;
  logic [7:0] OutData;
  logic       OutValid;
  logic       OutReady = 1'b1;
  logic       OutLast;
  logic [7:0] DropCount;
  logic       Busy;

  int n_checks = 0;
  int n_pass   = 0;

  sort_report_packer dut (
    .clk(clk), .rst(rst), .SortValid(SortValid),
    .MaxCountData1(d1), .MaxCountData2(d2), .MaxCountData3(d3),
    .MaxCount1(c1), .MaxCount2(c2), .MaxCount3(c3),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .OutLast(OutLast), .DropCount(DropCount), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic pkt_t mk_pkt(input logic [7:0] s, input int a1, input int b1,
                                  input int a2, input int b2, input int a3, input int b3);
    pkt_t p;
    p[0] = 8'hA5; p[1] = s;
    p[2] = 8'(a1); p[3] = 8'(b1); p[4] = 8'(a2); p[5] = 8'(b2); p[6] = 8'(a3); p[7] = 8'(b3);
    p[8] = 8'h00;
    for (int k = 0; k < 8; k++) p[8] = p[8] ^ p[k];
    return p;
  endfunction

  // Called just after a rising edge; pulses SortValid for one cycle.
  task automatic send_result(input int a1, input int b1, input int a2, input int b2,
                             input int a3, input int b3);
    d1 = 4'(a1); c1 = 6'(b1); d2 = 4'(a2); c2 = 6'(b2); d3 = 4'(a3); c3 = 6'(b3);
    SortValid = 1'b1;
    @(posedge clk); #1;
    SortValid = 1'b0;
  endtask

  // Collects one packet; lat = cycles until OutValid first seen (0 means next cycle).
  task automatic recv_packet(input pkt_t exp, input bit toggle, output int lat);
    int i, cyc, first_xfer;
    logic [7:0] held;
    logic held_last;
    bit stalled;
    i = 0; cyc = 0; lat = -1; first_xfer = -1; stalled = 1'b0; held = 8'h00; held_last = 1'b0;
    while (i < 9 && cyc < 200) begin
      @(negedge clk);
      if (OutValid && lat < 0) lat = cyc;
      if (stalled) begin
        check("hold_data", OutData, held);
        check("hold_valid", OutValid, 1'b1);
        check("hold_last", OutLast, held_last);
      end
      if (OutValid && OutReady) begin
        check($sformatf("byte%0d", i), OutData, exp[i]);
        check($sformatf("last%0d", i), OutLast, (i == 8));
        if (first_xfer < 0) first_xfer = cyc;
        if (!toggle) check("consecutive", 16'(cyc), 16'(first_xfer + i));
        i++;
        stalled = 1'b0;
      end else begin
        stalled   = OutValid;
        held      = OutData;
        held_last = OutLast;
      end
      @(posedge clk); #1;
      cyc++;
      if (toggle) OutReady = ~OutReady;
    end
    if (i < 9) check("packet_timeout", 16'(i), 16'd9);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, Busy, 1'b0);
    check({tag, "_valid"}, OutValid, 1'b0);
  endtask

  pkt_t p, q;
  int   lat;

  initial begin
    // Reset values and a SortValid coinciding with reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", OutValid, 1'b0);
    check("rst_data", OutData, 8'h00);
    check("rst_last", OutLast, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_drop", DropCount, 8'h00);
    @(posedge clk); #1;
    SortValid = 1'b1;
    @(posedge clk); #1;
    SortValid = 1'b0; rst = 1'b0;
    expect_idle("rst_sv_ignored");

    // Single packet, hand-computed bytes
    @(posedge clk); #1;
    p = '{8'hA5, 8'h00, 8'h03, 8'h14, 8'h07, 8'h0F, 8'h00, 8'h09, 8'hB3};
    send_result(3, 20, 7, 15, 0, 9);
    recv_packet(p, 1'b0, lat);
    check("latency", 16'(lat), 16'd0);
    expect_idle("after_pkt");

    // Backpressure with OutReady toggling 1010...
    OutReady = 1'b1;
    p = '{8'hA5, 8'h01, 8'h03, 8'h14, 8'h07, 8'h0F, 8'h00, 8'h09, 8'hB2};
    send_result(3, 20, 7, 15, 0, 9);
    recv_packet(p, 1'b1, lat);
    OutReady = 1'b1;
    expect_idle("after_bp");

    // Back-to-back: second result arrives at byte 3
    do_reset();
    p = mk_pkt(8'h00, 3, 20, 7, 15, 0, 9);
    q = mk_pkt(8'h01, 5, 33, 2, 17, 1, 4);
    send_result(3, 20, 7, 15, 0, 9);
    fork
      recv_packet(p, 1'b0, lat);
      begin repeat (3) @(posedge clk); #1; send_result(5, 33, 2, 17, 1, 4); end
    join
    recv_packet(q, 1'b0, lat);
    check("b2b_latency", 16'(lat), 16'd0);
    check("b2b_drop", DropCount, 8'h00);
    expect_idle("after_b2b");

    // Overrun: 2nd result buffered, 3rd lost
    p = mk_pkt(8'h02, 1, 1, 2, 2, 3, 3);
    q = mk_pkt(8'h03, 9, 40, 8, 30, 7, 20);
    send_result(1, 1, 2, 2, 3, 3);
    fork
      recv_packet(p, 1'b0, lat);
      begin
        repeat (2) @(posedge clk); #1; send_result(9, 40, 8, 30, 7, 20);
        repeat (2) @(posedge clk); #1; send_result(15, 63, 15, 63, 15, 63);
      end
    join
    check("ovr_drop", DropCount, 8'h01);
    recv_packet(q, 1'b0, lat);
    check("ovr_latency", 16'(lat), 16'd0);
    expect_idle("after_ovr");

    // New result coinciding with the last-byte transfer goes straight to active
    p = mk_pkt(8'h04, 6, 6, 5, 5, 4, 4);
    q = mk_pkt(8'h05, 12, 50, 11, 49, 10, 48);
    send_result(6, 6, 5, 5, 4, 4);
    fork
      recv_packet(p, 1'b0, lat);
      begin repeat (8) @(posedge clk); #1; send_result(12, 50, 11, 49, 10, 48); end
    join
    recv_packet(q, 1'b0, lat);
    check("direct_latency", 16'(lat), 16'd0);
    check("direct_drop", DropCount, 8'h01);
    expect_idle("after_direct");

    // Reset mid-packet: abandoned, not resumed, SeqNum back to 00
    send_result(3, 20, 7, 15, 0, 9);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", OutValid, 1'b0);
    check("midrst_drop", DropCount, 8'h00);
    repeat (4) @(posedge clk); #1;
    expect_idle("midrst_no_resume");
    p = mk_pkt(8'h00, 3, 20, 7, 15, 0, 9);
    send_result(3, 20, 7, 15, 0, 9);
    recv_packet(p, 1'b0, lat);

    // SeqNum wrap: 256 more packets, last one carries 00 again
    for (int n = 0; n < 256; n++) begin
      p = mk_pkt(8'(n + 1), n % 16, n % 64, 15 - (n % 16), 1, 2, 3);
      send_result(n % 16, n % 64, 15 - (n % 16), 1, 2, 3);
      recv_packet(p, 1'b0, lat);
    end
    check("wrap_seq", p[1], 8'h00);

    // Drop saturation: stalled packet, 301 results (1 buffered, 300 dropped)
    OutReady = 1'b0;
    send_result(1, 2, 3, 4, 5, 6);
    d1 = 4'd10; c1 = 6'd11; d2 = 4'd12; c2 = 6'd13; d3 = 4'd14; c3 = 6'd15;
    SortValid = 1'b1;
    @(posedge clk); #1;
    d1 = 4'd0; c1 = 6'd0; d2 = 4'd0; c2 = 6'd0; d3 = 4'd0; c3 = 6'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drop_5", DropCount, 8'h05);
    repeat (295) @(posedge clk);
    #1 SortValid = 1'b0;
    @(negedge clk);
    check("drop_sat", DropCount, 8'hFF);
    @(posedge clk); #1;
    OutReady = 1'b1;
    p = mk_pkt(8'h01, 1, 2, 3, 4, 5, 6);
    q = mk_pkt(8'h02, 10, 11, 12, 13, 14, 15);
    recv_packet(p, 1'b0, lat);
    recv_packet(q, 1'b0, lat);
    check("sat_pend_latency", 16'(lat), 16'd0);
    expect_idle("after_sat");
    check("drop_hold", DropCount, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
